ofs_fim_mmio_cpl_gen: RTL and testbench

// Responder side of PCIe MMIO reads on P-tile AVST: captures MMIO read request headers from RX
// and matches them in order with CSR read data. Builds CplD/Cpl TLPs (128b hdr + 256b data) on
// one TX AVST channel, single-beat packets (sop=eop=1). Sits between RX MMIO demux, CSR fabric, TX arbiter.

---
 rtl/ofs_fim_mmio_cpl_gen_if.sv | 54 +++++
 rtl/ofs_fim_mmio_cpl_gen.sv | 173 +++++++++++++++++
 tb/tb_ofs_fim_mmio_cpl_gen.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_mmio_cpl_gen_if.sv
// Bundle of the request, response and completion channels of the MMIO
// completion generator.
//   slave  : the completion generator's view. It receives requests and CSR data,
//            and it drives completion TLPs and the pending count.
//   master : the surrounding fabric's view (RX demux, CSR fabric, TX arbiter).
// Signals:
//   req_*   MMIO read request header channel (valid/ready)
//   rsp_*   CSR read data channel, in request order (valid/ready)
//   tx_*    completion TLP channel, single-beat AVST (valid/ready)
//   cpl_pending  stored requests not yet turned into completions
interface ofs_fim_mmio_cpl_gen_if #(
  parameter int PF_WIDTH = 3,
  parameter int VF_WIDTH = 6,
  parameter int CNT_W    = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [127:0]        req_hdr;
  logic [PF_WIDTH-1:0] req_pfn;
  logic [VF_WIDTH-1:0] req_vfn;
  logic                req_vf_active;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [63:0]         rsp_data;

  logic                tx_valid;
  logic                tx_ready;
  logic                tx_sop;
  logic                tx_eop;
  logic [127:0]        tx_hdr;
  logic [255:0]        tx_data;
  logic                tx_vf_active;

  logic [CNT_W-1:0]    cpl_pending;

  modport slave (
    input  req_valid, req_hdr, req_pfn, req_vfn, req_vf_active,
    input  rsp_valid, rsp_data,
    input  tx_ready,
    output req_ready, rsp_ready,
    output tx_valid, tx_sop, tx_eop, tx_hdr, tx_data, tx_vf_active,
    output cpl_pending
  );

  modport master (
    output req_valid, req_hdr, req_pfn, req_vfn, req_vf_active,
    output rsp_valid, rsp_data,
    output tx_ready,
    input  req_ready, rsp_ready,
    input  tx_valid, tx_sop, tx_eop, tx_hdr, tx_data, tx_vf_active,
    input  cpl_pending
  );
endinterface

// File: rtl/ofs_fim_mmio_cpl_gen.sv
// MMIO read completion generator (P-tile AVST, single-beat packets).
// It captures MMIO read request headers into an in-order FIFO. It pairs each
// request with the next CSR read data word and emits one CplD per request. A
// request with an unsupported length (0 = 1024DW, or more than 2DW) gets a Cpl
// with Completer Abort and does not consume CSR data.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cfg_bus     captured bus number. Completer ID = {cfg_bus, pfn zero-extended to 8b}
//   io          request/response/completion channels (slave modport)
module ofs_fim_mmio_cpl_gen #(
  parameter int REQ_DEPTH = 8,
  parameter int PF_WIDTH  = 3,
  parameter int VF_WIDTH  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_bus,
  ofs_fim_mmio_cpl_gen_if.slave io
);

  localparam int            AW        = $clog2(REQ_DEPTH);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(REQ_DEPTH);

  // Only the fields a completion needs are kept. The 3DW/4DW address choice is
  // resolved at capture, so the format bit is not stored.
  typedef struct packed {
    logic [9:0]          len;
    logic [2:0]          tc;
    logic [2:0]          attr;
    logic [15:0]         reqid;
    logic [7:0]          tag;
    logic [6:0]          addr_lo;
    logic [PF_WIDTH-1:0] pfn;
    logic                vf_active;
  } req_info_t;

  // ---------------------------------------------------------------------------
  // Request-info FIFO. The pointers carry one extra wrap bit, so their
  // difference is the occupancy.
  // ---------------------------------------------------------------------------
  req_info_t   mem [REQ_DEPTH];
  req_info_t   wr_info;
  req_info_t   head;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        full, nonempty, push, pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == DEPTH_CNT);
  assign nonempty = (count != '0);
  assign push     = io.req_valid & ~full;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_info           = '0;
    wr_info.len       = io.req_hdr[105:96];
    wr_info.tc        = io.req_hdr[118:116];
    wr_info.attr      = {io.req_hdr[114], io.req_hdr[109:108]};
    wr_info.reqid     = io.req_hdr[95:80];
    wr_info.tag       = io.req_hdr[79:72];
    // 4DW headers carry the low address in DW3. 3DW headers carry it in DW2.
    wr_info.addr_lo   = io.req_hdr[125] ? io.req_hdr[6:0] : io.req_hdr[38:32];
    wr_info.pfn       = io.req_pfn;
    wr_info.vf_active = io.req_vf_active;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_info;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Head classification and output-slot handshake.
  // ---------------------------------------------------------------------------
  logic [1:0] vld_pipe;   // [0] = slot load this cycle, [1] = slot holds a TLP
  logic       head_good, load_ok, good_load, bad_load;

  assign head_good = (head.len == 10'd1) || (head.len == 10'd2);
  // The slot can take a new TLP when it is empty or being drained this cycle.
  // This allows one completion per clock.
  assign load_ok   = ~vld_pipe[1] | io.tx_ready;
  assign io.rsp_ready = nonempty & head_good & load_ok;
  assign good_load = io.rsp_valid & io.rsp_ready;
  // Unsupported lengths complete with CA on their own, with no CSR data.
  assign bad_load  = nonempty & ~head_good & load_ok;
  assign pop       = good_load | bad_load;
  assign vld_pipe[0] = pop;

  // ---------------------------------------------------------------------------
  // Completion TLP assembly from the FIFO head.
  // ---------------------------------------------------------------------------
  logic [127:0] cpl_hdr;
  logic [255:0] cpl_data;

  always_comb begin
    cpl_hdr  = '0;
    cpl_data = '0;
    // DW0
    cpl_hdr[124:120] = 5'b01010;
    cpl_hdr[118:116] = head.tc;
    cpl_hdr[114]     = head.attr[2];
    cpl_hdr[109:108] = head.attr[1:0];
    // DW1: completer ID. Status, BCM and byte count are filled in below.
    cpl_hdr[95:80]   = {cfg_bus, 8'(head.pfn)};
    // DW2: requester ID, tag and lower address (DW aligned)
    cpl_hdr[63:48]   = head.reqid;
    cpl_hdr[47:40]   = head.tag;
    cpl_hdr[38:32]   = {head.addr_lo[6:2], 2'b00};
    if (head_good) begin
      cpl_hdr[127:125] = 3'b010;
      cpl_hdr[105:96]  = head.len;
      cpl_hdr[75:64]   = {head.len, 2'b00};
      if (head.len[1]) begin
        cpl_data[63:0] = io.rsp_data;
      end else begin
        // Single DW read: pick the half of the QW the address points at.
        cpl_data[31:0] = head.addr_lo[2] ? io.rsp_data[63:32] : io.rsp_data[31:0];
      end
    end else begin
      cpl_hdr[127:125] = 3'b000;
      cpl_hdr[79:77]   = 3'b100;
      cpl_hdr[75:64]   = 12'd4;
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot. Its contents stay stable while tx_valid waits for tx_ready.
  // ---------------------------------------------------------------------------
  logic [127:0] tx_hdr_q;
  logic [255:0] tx_data_q;
  logic         tx_vfa_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      tx_hdr_q    <= '0;
      tx_data_q   <= '0;
      tx_vfa_q    <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0] | (vld_pipe[1] & ~io.tx_ready);
      if (vld_pipe[0]) begin
        tx_hdr_q  <= cpl_hdr;
        tx_data_q <= cpl_data;
        tx_vfa_q  <= head.vf_active;
      end
    end
  end

  assign io.req_ready    = ~full;
  assign io.tx_valid     = vld_pipe[1];
  assign io.tx_sop       = vld_pipe[1];
  assign io.tx_eop       = vld_pipe[1];
  assign io.tx_hdr       = tx_hdr_q;
  assign io.tx_data      = tx_data_q;
  assign io.tx_vf_active = tx_vfa_q;
  assign io.cpl_pending  = count;

  // The VF number and the remaining request header fields do not affect the completion.
  logic                unused_hdr;
  logic [VF_WIDTH-1:0] unused_vfn;
  assign unused_hdr = ^io.req_hdr;
  assign unused_vfn = io.req_vfn;

endmodule

// File: tb/tb_ofs_fim_mmio_cpl_gen.sv
`timescale 1ns/1ps
module tb_ofs_fim_mmio_cpl_gen;
  localparam int REQ_DEPTH = 8;
  localparam int PF_WIDTH  = 3;
  localparam int VF_WIDTH  = 6;
  localparam int CNT_W     = $clog2(REQ_DEPTH) + 1;
  localparam logic [7:0] CFG_BUS = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg_bus = CFG_BUS;
  always #5 clk = ~clk;

  ofs_fim_mmio_cpl_gen_if #(.PF_WIDTH(PF_WIDTH), .VF_WIDTH(VF_WIDTH), .CNT_W(CNT_W)) bus();

  ofs_fim_mmio_cpl_gen #(.REQ_DEPTH(REQ_DEPTH), .PF_WIDTH(PF_WIDTH), .VF_WIDTH(VF_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_bus(cfg_bus), .io(bus)
  );

  typedef struct {
    bit          fmt4;
    logic [9:0]  len;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [15:0] reqid;
    logic [7:0]  tag;
    logic [6:0]  addr;
    logic [2:0]  pfn;
    logic [5:0]  vfn;
    bit          vfa;
  } req_t;

  req_t        exp_q[$];     // requests accepted, completion not yet taken
  logic [63:0] rsp_done[$];  // CSR words accepted, in order
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(bit fmt4, logic [9:0] len, logic [2:0] tc, logic [2:0] attr,
                              logic [15:0] reqid, logic [7:0] tag, logic [6:0] addr,
                              logic [2:0] pfn, logic [5:0] vfn, bit vfa);
    req_t r;
    r.fmt4 = fmt4; r.len = len; r.tc = tc; r.attr = attr; r.reqid = reqid;
    r.tag = tag; r.addr = addr; r.pfn = pfn; r.vfn = vfn; r.vfa = vfa;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   sel;
    sel = $urandom_range(0, 9);
    r.fmt4  = 1'($urandom_range(0, 1));
    r.len   = (sel < 4) ? 10'd1 : (sel < 7) ? 10'd2 : (sel == 7) ? 10'd0 :
              (sel == 8) ? 10'd3 : 10'($urandom);
    r.tc    = 3'($urandom);
    r.attr  = 3'($urandom);
    r.reqid = 16'($urandom);
    r.tag   = 8'($urandom);
    r.addr  = 7'($urandom);
    r.pfn   = 3'($urandom);
    r.vfn   = 6'($urandom);
    r.vfa   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // MRd header. Unused address bits are random so that wrong field selection shows up.
  function automatic logic [127:0] mk_hdr(req_t r);
    logic [127:0] h;
    logic [31:0]  junk;
    junk = $urandom;
    h = '0;
    h[127:125] = r.fmt4 ? 3'b001 : 3'b000;
    h[118:116] = r.tc;
    h[114]     = r.attr[2];
    h[109:108] = r.attr[1:0];
    h[105:96]  = r.len;
    h[95:80]   = r.reqid;
    h[79:72]   = r.tag;
    h[71:64]   = 8'hFF;
    if (r.fmt4) begin
      h[63:32] = $urandom;
      h[31:7]  = junk[24:0];
      h[6:0]   = r.addr;
    end else begin
      h[63:39] = junk[24:0];
      h[38:32] = r.addr;
      h[31:0]  = $urandom;
    end
    return h;
  endfunction

  function automatic logic [127:0] exp_hdr(req_t r);
    logic [127:0] h;
    bit           good;
    good = (r.len == 10'd1) || (r.len == 10'd2);
    h = '0;
    h[127:125] = good ? 3'b010 : 3'b000;
    h[124:120] = 5'b01010;
    h[118:116] = r.tc;
    h[114]     = r.attr[2];
    h[109:108] = r.attr[1:0];
    h[105:96]  = good ? r.len : 10'd0;
    h[95:88]   = CFG_BUS;
    h[87:80]   = {5'b0, r.pfn};
    h[79:77]   = good ? 3'b000 : 3'b100;
    h[75:64]   = good ? 12'(r.len * 4) : 12'd4;
    h[63:48]   = r.reqid;
    h[47:40]   = r.tag;
    h[38:32]   = {r.addr[6:2], 2'b00};
    return h;
  endfunction

  function automatic logic [255:0] exp_data(req_t r, logic [63:0] d);
    logic [255:0] x;
    x = '0;
    if (r.len == 10'd2)      x[63:0] = d;
    else if (r.len == 10'd1) x[31:0] = r.addr[2] ? d[63:32] : d[31:0];
    return x;
  endfunction

  // Compare the TLP currently in the slot with the oldest outstanding request.
  task automatic check_tx(input string tag);
    req_t        r;
    logic [63:0] d;
    chk({tag, "_avail"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() == 0) return;
    r = exp_q.pop_front();
    d = '0;
    if (r.len == 10'd1 || r.len == 10'd2) d = (rsp_done.size() > 0) ? rsp_done.pop_front() : 'x;
    chk({tag, "_hdr"},  bus.tx_hdr, exp_hdr(r));
    chk({tag, "_data"}, bus.tx_data, exp_data(r, d));
    chk({tag, "_vfa"},  bus.tx_vf_active, r.vfa);
    chk({tag, "_sopeop"}, {bus.tx_sop, bus.tx_eop}, 2'b11);
  endtask

  task automatic drive_req(input req_t r);
    bus.req_valid     = 1'b1;
    bus.req_hdr       = mk_hdr(r);
    bus.req_pfn       = r.pfn;
    bus.req_vfn       = r.vfn;
    bus.req_vf_active = r.vfa;
  endtask

  // All handshake tasks start and end just after a rising edge.
  task automatic push_req(input req_t r);
    bit ok = 0;
    int n = 0;
    drive_req(r);
    while (!ok && n < 50) begin
      @(negedge clk); ok = bus.req_ready;
      @(posedge clk); #1; n++;
    end
    bus.req_valid = 1'b0;
    chk("req_accept", ok, 1'b1);
    if (ok) exp_q.push_back(r);
  endtask

  task automatic give_rsp(input logic [63:0] d);
    bit ok = 0;
    int n = 0;
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = d;
    while (!ok && n < 50) begin
      @(negedge clk); ok = bus.rsp_ready;
      @(posedge clk); #1; n++;
    end
    bus.rsp_valid = 1'b0;
    chk("rsp_accept", ok, 1'b1);
    if (ok) rsp_done.push_back(d);
  endtask

  task automatic take_tx(input string tag);
    bit ok = 0;
    int n = 0;
    bus.tx_ready = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk); ok = bus.tx_valid;
      if (ok) check_tx(tag);
      @(posedge clk); #1; n++;
    end
    bus.tx_ready = 1'b0;
    chk({tag, "_seen"}, ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  req_t         cur;
  logic [127:0] hold_hdr;
  logic [255:0] hold_data;
  bit           prev_stall, req_acc, rsp_acc;
  int           pushed_n, txn, k;

  initial begin
    bus.req_valid = 0; bus.req_hdr = '0; bus.req_pfn = '0; bus.req_vfn = '0;
    bus.req_vf_active = 0; bus.rsp_valid = 0; bus.rsp_data = '0; bus.tx_ready = 0;

    // ---- reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_pending",  bus.cpl_pending, 0);
    chk("rst_hdr",      bus.tx_hdr, 0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_ready", bus.rsp_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- 3DW, len 1, addr 0x04: the upper DW of the QW is returned
    push_req(mk(0, 10'd1, 3'd0, 3'd0, 16'h0100, 8'h2A, 7'h04, 3'd2, 6'd0, 0));
    give_rsp(64'h11223344_55667788);
    @(negedge clk);
    chk("t1_latency", bus.tx_valid, 1'b1);
    chk("t1_len",  bus.tx_hdr[105:96], 10'd1);
    chk("t1_bc",   bus.tx_hdr[75:64], 12'd4);
    chk("t1_la",   bus.tx_hdr[38:32], 7'h04);
    chk("t1_tag",  bus.tx_hdr[47:40], 8'h2A);
    chk("t1_dw0",  bus.tx_data[31:0], 32'h11223344);
    @(posedge clk); #1;
    take_tx("t1");

    // ---- 4DW, len 2, addr 0x08, tx_ready held high
    push_req(mk(1, 10'd2, 3'd3, 3'b101, 16'h0203, 8'h11, 7'h08, 3'd5, 6'd9, 1));
    bus.tx_ready = 1'b1;
    give_rsp(64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    chk("t2_latency", bus.tx_valid, 1'b1);
    chk("t2_qw", bus.tx_data[63:0], 64'hDEADBEEF_CAFEF00D);
    chk("t2_bc", bus.tx_hdr[75:64], 12'd8);
    check_tx("t2");
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_drained", bus.tx_valid, 1'b0);
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;

    // ---- len 4: Cpl with CA, CSR data not consumed
    push_req(mk(0, 10'd4, 3'd1, 3'd2, 16'h0A0B, 8'h33, 7'h1C, 3'd1, 6'd3, 0));
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 64'h0BAD0BAD_0BAD0BAD;
    @(negedge clk);
    chk("t3_rsp_blocked", bus.rsp_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_valid",  bus.tx_valid, 1'b1);
    chk("t3_fmt",    bus.tx_hdr[127:125], 3'b000);
    chk("t3_status", bus.tx_hdr[79:77], 3'b100);
    chk("t3_len",    bus.tx_hdr[105:96], 10'd0);
    chk("t3_bc",     bus.tx_hdr[75:64], 12'd4);
    chk("t3_rsp_still_blocked", bus.rsp_ready, 1'b0);
    check_tx("t3");
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    bus.tx_ready  = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready  = 1'b0;
    push_req(mk(0, 10'd1, 3'd0, 3'd0, 16'h0C0D, 8'h34, 7'h00, 3'd0, 6'd0, 0));
    give_rsp(64'h01234567_89ABCDEF);
    take_tx("t3_next");

    // ---- fill the FIFO, then drain back-to-back
    for (int i = 0; i < REQ_DEPTH; i++)
      push_req(mk(i[0], 10'(i % 2 + 1), 3'(i), 3'(i), 16'(16'h1000 + i), 8'(8'h40 + i),
                  7'(i * 12), 3'(i), 6'(i), i[1]));
    @(negedge clk);
    chk("t4_full_ready", bus.req_ready, 1'b0);
    chk("t4_pending8",   bus.cpl_pending, REQ_DEPTH);
    @(posedge clk); #1;
    k = 0; txn = 0;
    bus.tx_ready  = 1'b1;
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = {32'hC0DE0000, 32'h01010101};
    for (int cyc = 0; cyc < 40 && txn < REQ_DEPTH; cyc++) begin
      @(negedge clk);
      if (bus.tx_valid) begin check_tx($sformatf("t4_%0d", txn)); txn++; end
      if (cyc >= 1 && cyc <= REQ_DEPTH) chk("t4_b2b_valid", bus.tx_valid, 1'b1);
      if (cyc < REQ_DEPTH) chk("t4_b2b_rsp_ready", bus.rsp_ready, 1'b1);
      if (bus.rsp_valid && bus.rsp_ready) begin rsp_done.push_back(bus.rsp_data); k++; end
      @(posedge clk); #1;
      if (k == REQ_DEPTH) bus.rsp_valid = 1'b0;
      else bus.rsp_data = {32'(32'hC0DE0000 + k), 32'(32'h01010101 * (k + 1))};
    end
    chk("t4_count", txn, REQ_DEPTH);
    bus.tx_ready = 1'b0;
    @(negedge clk);
    chk("t4_pending0", bus.cpl_pending, 0);
    chk("t4_idle", bus.tx_valid, 1'b0);
    @(posedge clk); #1;

    // ---- back-pressure for 5 clocks
    push_req(mk(1, 10'd2, 3'd2, 3'd1, 16'h2222, 8'h50, 7'h10, 3'd4, 6'd1, 1));
    give_rsp(64'h5555AAAA_12345678);
    push_req(mk(0, 10'd1, 3'd0, 3'd4, 16'h3333, 8'h55, 7'h44, 3'd6, 6'd2, 0));
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 64'h87654321_0FEDCBA9;
    @(negedge clk);
    hold_hdr  = bus.tx_hdr;
    hold_data = bus.tx_data;
    check_tx("t5_a");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_hold_hdr",  bus.tx_hdr, hold_hdr);
      chk("t5_hold_data", bus.tx_data, hold_data);
      chk("t5_hold_vld",  bus.tx_valid, 1'b1);
      chk("t5_rsp_ready_low", bus.rsp_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    chk("t5_release_rsp_ready", bus.rsp_ready, 1'b1);
    rsp_done.push_back(bus.rsp_data);
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
    @(negedge clk);
    chk("t5_next_valid", bus.tx_valid, 1'b1);
    check_tx("t5_b");
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;

    // ---- randomized traffic against the queue model
    pushed_n = 0; req_acc = 0; rsp_acc = 0; prev_stall = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      if (req_acc) bus.req_valid = 1'b0;
      if (rsp_acc) bus.rsp_valid = 1'b0;
      req_acc = 0; rsp_acc = 0;
      if (!bus.req_valid && pushed_n < 150 && $urandom_range(0, 2) != 0) begin
        cur = rand_req();
        drive_req(cur);
      end
      if (!bus.rsp_valid && $urandom_range(0, 1) == 1) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {$urandom, $urandom};
      end
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rnd_pending", bus.cpl_pending, exp_q.size() - (bus.tx_valid ? 1 : 0));
      if (prev_stall) begin
        chk("rnd_hold_vld",  bus.tx_valid, 1'b1);
        chk("rnd_hold_hdr",  bus.tx_hdr, hold_hdr);
        chk("rnd_hold_data", bus.tx_data, hold_data);
      end
      if (bus.tx_valid && bus.tx_ready) check_tx("rnd");
      if (bus.req_valid && bus.req_ready) begin exp_q.push_back(cur); pushed_n++; req_acc = 1; end
      if (bus.rsp_valid && bus.rsp_ready) begin rsp_done.push_back(bus.rsp_data); rsp_acc = 1; end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      hold_hdr   = bus.tx_hdr;
      hold_data  = bus.tx_data;
      if (pushed_n == 150 && exp_q.size() == 0) break;
    end
    chk("rnd_all_done", (pushed_n == 150) && (exp_q.size() == 0), 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.tx_ready  = 1'b0;
    rsp_done.delete();

    // ---- asynchronous reset with work outstanding
    push_req(mk(0, 10'd1, 3'd0, 3'd0, 16'h4444, 8'h60, 7'h00, 3'd0, 6'd0, 1));
    give_rsp(64'hFFFF0000_AAAA5555);
    for (int i = 0; i < 3; i++)
      push_req(mk(1, 10'd2, 3'd0, 3'd0, 16'h4444, 8'(8'h61 + i), 7'h08, 3'd0, 6'd0, 0));
    @(negedge clk);
    chk("t7_pending3", bus.cpl_pending, 3);
    chk("t7_valid",    bus.tx_valid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t7_async_valid",   bus.tx_valid, 1'b0);
    chk("t7_async_pending", bus.cpl_pending, 0);
    chk("t7_async_hdr",     bus.tx_hdr, 0);
    chk("t7_async_data",    bus.tx_data, 0);
    chk("t7_async_vfa",     bus.tx_vf_active, 1'b0);
    exp_q.delete();
    rsp_done.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_req(mk(0, 10'd2, 3'd7, 3'd7, 16'hBEEF, 8'h77, 7'h38, 3'd7, 6'd63, 1));
    give_rsp(64'h0F0F0F0F_F0F0F0F0);
    take_tx("t7_after");
    @(negedge clk);
    chk("t7_end_pending", bus.cpl_pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
